// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Elastic pipeline-stage register carrying a DATA_W-bit payload
//             under a valid/ready handshake. It has a synchronous flush, and
//             the control LSBs of out_data are forced to zero while the stage
//             is empty.
//  Options  : define PIPE_SKID_EN to build the two-entry skid buffer. That
//             build has a registered in_ready. Without it there is a single
//             entry and in_ready depends combinationally on out_ready.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 105,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_v_q && out_ready;
  assign out_valid = main_v_q;

  // Present the main entry. Mask its control field whenever the stage holds a bubble.
  always_comb begin
    out_data = main_q;
    if (!main_v_q) begin
      out_data[CTRL_W-1:0] = '0;
    end
  end

`ifdef PIPE_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  // in_ready comes straight from a flop, so out_ready has no path to it.
  assign in_ready  = !skid_v_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

  // Next-state logic for EMPTY / ONE / FULL. The state is encoded by main_v and skid_v.
  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (flush) begin
      // Flush kills both entries. Payload flops keep their contents.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      // FULL: no input is possible, and draining promotes skid into main.
      if (out_xfer) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (main_v_q) begin
      // ONE state.
      if (in_xfer && out_xfer) begin
        main_d = in_data;
      end else if (in_xfer) begin
        skid_d   = in_data;
        skid_v_d = 1'b1;
      end else if (out_xfer) begin
        main_v_d = 1'b0;
      end
    end else if (in_xfer) begin
      // EMPTY state.
      main_d   = in_data;
      main_v_d = 1'b1;
    end
  end

  // Skid entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
    end
  end
`else
  // A single entry can take new data whenever its current entry leaves this cycle.
  assign in_ready  = !main_v_q || out_ready;
  assign occupancy = {1'b0, main_v_q};

  // Next-state logic for the single entry: load on input, and empty on output only.
  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    if (flush) begin
      main_v_d = 1'b0;
    end else if (in_xfer) begin
      main_d   = in_data;
      main_v_d = 1'b1;
    end else if (out_xfer) begin
      main_v_d = 1'b0;
    end
  end
`endif

  // Main entry storage. Reset clears it, so out_data reads zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      main_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      main_q   <= main_d;
    end
  end

endmodule
`default_nettype wire
